// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM
// states, instruction classes and the control-field encodings that the
// datapath blocks (immediate generator, ALU, writeback mux) also decode.
package riscv_ctrl_pkg;

    // Major opcodes understood by the controller
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_I      = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5,
        CL_LUI    = 3'd6,
        CL_ILL    = 3'd7
    } iclass_t;

    // Immediate format select, shared with the immediate generator
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_BRCMP = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic PC_SRC_PLUS4 = 1'b0;
    localparam logic PC_SRC_TGT   = 1'b1;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_TIMEOUT = 2'd2;

endpackage

// File: rtl/riscv_mc_decode.sv
// Combinational opcode classifier: instruction class, legality and the
// immediate format the target-precompute step needs.
module riscv_mc_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       legal,
    output logic [2:0] imm_type
);

    // Map the major opcode onto a class and its immediate format
    always_comb begin
        iclass   = CL_ILL;
        imm_type = IMM_I;
        case (opcode)
            OPC_R:      iclass = CL_R;
            OPC_I:      iclass = CL_I;
            OPC_LOAD:   iclass = CL_LOAD;
            OPC_STORE:  begin iclass = CL_STORE;  imm_type = IMM_S; end
            OPC_BRANCH: begin iclass = CL_BRANCH; imm_type = IMM_B; end
            OPC_JAL:    begin iclass = CL_JAL;    imm_type = IMM_J; end
            OPC_LUI:    begin iclass = CL_LUI;    imm_type = IMM_U; end
            default:    iclass = CL_ILL;
        endcase
        legal = (iclass != CL_ILL);
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM. Strobes are decoded from the registered
// state and the held IR; the memory-handshake strobes are Mealy on mem_ready.
// Includes the memory watchdog, sticky trap and retired-instruction counter.
module riscv_mc_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             tgt_we,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_type,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state;
    logic [1:0]      cause_q;
    logic            fetch_pend;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            retire;

    iclass_t         iclass;
    logic            legal;
    logic [2:0]      dec_imm;

    // Only the major opcode steers control; funct fields go to the ALU
    logic            ir_unused;
    assign ir_unused = ^ir[31:7];

    riscv_mc_decode u_decode (
        .opcode   (ir[6:0]),
        .iclass   (iclass),
        .legal    (legal),
        .imm_type (dec_imm)
    );

    // The watchdog fires on the last allowed waiting cycle so mem_req is
    // already low in the cycle after TIMEOUT waiting cycles
    assign wd_hit = (TIMEOUT > 0) && mem_req && !mem_ready &&
                    (wd_cnt == WD_W'(TIMEOUT - 1));

    assign retire = ((state == ST_EXEC) && (iclass == CL_BRANCH)) ||
                    ((state == ST_MEM) && mem_ready && (iclass == CL_STORE)) ||
                    (state == ST_WB);

    // Control strobes; everything is forced low while reset is asserted so
    // an in-flight memory request drops asynchronously
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_PLUS4;
        tgt_we     = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op     = ALU_ADD;
        imm_type   = IMM_I;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        trap       = 1'b0;
        trap_cause = TC_NONE;
        if (rst_n) begin
            trap_cause = cause_q;
            case (state)
                ST_FETCH: begin
                    // Once a fetch is issued it is held even if run drops
                    if (run || fetch_pend) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_we = 1'b1;
                            pc_we = 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        tgt_we    = 1'b1;
                        imm_type  = dec_imm;
                    end
                end
                ST_EXEC: begin
                    case (iclass)
                        CL_R: alu_op = ALU_FUNCT;
                        CL_I: begin
                            alu_b_sel = 1'b1;
                            alu_op    = ALU_FUNCT;
                        end
                        CL_LOAD, CL_STORE: begin
                            alu_b_sel = 1'b1;
                            tgt_we    = 1'b1;
                            imm_type  = dec_imm;
                        end
                        CL_BRANCH: begin
                            alu_op = ALU_BRCMP;
                            if (br_taken) begin
                                pc_we  = 1'b1;
                                pc_src = PC_SRC_TGT;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (iclass == CL_STORE);
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    case (iclass)
                        CL_LOAD: wb_sel = WB_MEM;
                        CL_LUI: begin
                            wb_sel   = WB_IMM;
                            imm_type = IMM_U;
                        end
                        CL_JAL: begin
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_TGT;
                        end
                        default: wb_sel = WB_ALU;
                    endcase
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    // State sequencing, sticky trap cause and pending-fetch tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            cause_q    <= TC_NONE;
            fetch_pend <= 1'b0;
        end else begin
            fetch_pend <= (state == ST_FETCH) && mem_req && !mem_ready && !wd_hit;
            if (wd_hit) begin
                state   <= ST_TRAP;
                cause_q <= TC_TIMEOUT;
            end else begin
                case (state)
                    ST_FETCH:  if (mem_req && mem_ready) state <= ST_DECODE;
                    ST_DECODE: begin
                        if (!legal) begin
                            state   <= ST_TRAP;
                            cause_q <= TC_ILLEGAL;
                        end else if (iclass == CL_JAL || iclass == CL_LUI) begin
                            state <= ST_WB;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        case (iclass)
                            CL_LOAD, CL_STORE: state <= ST_MEM;
                            CL_BRANCH:         state <= ST_FETCH;
                            default:           state <= ST_WB;
                        endcase
                    end
                    ST_MEM: begin
                        if (mem_ready)
                            state <= (iclass == CL_LOAD) ? ST_WB : ST_FETCH;
                    end
                    ST_WB:   state <= ST_FETCH;
                    ST_TRAP: state <= ST_TRAP;
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

    // Watchdog: count consecutive unanswered request cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if ((TIMEOUT > 0) && mem_req && !mem_ready)
            wd_cnt <= wd_cnt + WD_W'(1);
        else
            wd_cnt <= '0;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (retire)
            instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed instructions from the test
// plan, then randomized instructions and handshake delays, checked each
// cycle against a phase-level model of the instruction sequence.
module tb_riscv_mc_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // Phase and class codes used by the model
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;
    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_LUI = 6, C_ILL = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   ir = 32'h0;
    logic          br_taken = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, tgt_we;
    logic          alu_a_sel, alu_b_sel, reg_we, trap;
    logic [1:0]    alu_op, wb_sel, trap_cause;
    logic [2:0]    imm_type;
    logic [CW-1:0] instret;

    riscv_mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ir         (ir),
        .br_taken   (br_taken),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .tgt_we     (tgt_we),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_op     (alu_op),
        .imm_type   (imm_type),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, tgt_we,
                  alu_a_sel, alu_b_sel, alu_op, imm_type, reg_we, wb_sel,
                  trap, trap_cause};

    int n_pass = 0;
    int n_chk  = 0;
    int exp_ret = 0;
    int imm_of [0:6] = '{0, 0, 0, 1, 2, 3, 4};
    logic [6:0] opc_tab [0:6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, o, e);
    endtask

    function automatic int cls_of(input logic [31:0] i);
        for (int k = 0; k < 7; k++)
            if (i[6:0] == opc_tab[k]) return k;
        return C_ILL;
    endfunction

    // What every strobe should be in a given phase of a given instruction
    function automatic logic [19:0] exp_vec(input int ph, input int c, input bit rdy,
                                            input bit br, input logic [1:0] cause);
        logic mreq = 0, mwe = 0, asel = 0, irwe = 0, pcwe = 0, pcsrc = 0, tgt = 0;
        logic asl = 0, bsl = 0, rwe = 0, trp = 0;
        logic [1:0] aop = 0, wbs = 0;
        logic [2:0] imm = 0;
        case (ph)
            P_F: begin mreq = 1; irwe = rdy; pcwe = rdy; end
            P_D: if (c != C_ILL) begin
                asl = 1; bsl = 1; tgt = 1; imm = 3'(imm_of[c]);
            end
            P_E: case (c)
                C_R:  aop = 1;
                C_I:  begin bsl = 1; aop = 1; end
                C_LD: begin bsl = 1; tgt = 1; end
                C_ST: begin bsl = 1; tgt = 1; imm = 1; end
                C_BR: begin aop = 2; pcwe = br; pcsrc = br; end
                default: ;
            endcase
            P_M: begin mreq = 1; asel = 1; mwe = (c == C_ST); end
            P_W: begin
                rwe = 1;
                if (c == C_LD) wbs = 1;
                if (c == C_LUI) begin wbs = 3; imm = 4; end
                if (c == C_JAL) begin wbs = 2; pcwe = 1; pcsrc = 1; end
            end
            P_T: trp = 1;
            default: ;
        endcase
        return {mreq, mwe, asel, irwe, pcwe, pcsrc, tgt, asl, bsl, aop, imm,
                rwe, wbs, trp, cause};
    endfunction

    // Run one legal instruction: fw fetch wait cycles, mw memory wait cycles
    task automatic do_instr(input logic [31:0] instr, input bit br, input int fw, input int mw);
        int c;
        int ph[$];
        bit rd[$];
        c = cls_of(instr);
        for (int k = 0; k <= fw; k++) begin ph.push_back(P_F); rd.push_back(k == fw); end
        ph.push_back(P_D); rd.push_back(1'($urandom_range(0, 1)));
        if (c != C_JAL && c != C_LUI) begin
            ph.push_back(P_E); rd.push_back(1'($urandom_range(0, 1)));
        end
        if (c == C_LD || c == C_ST)
            for (int k = 0; k <= mw; k++) begin ph.push_back(P_M); rd.push_back(k == mw); end
        if (c == C_R || c == C_I || c == C_LD || c == C_JAL || c == C_LUI) begin
            ph.push_back(P_W); rd.push_back(1'($urandom_range(0, 1)));
        end
        ir = instr;
        foreach (ph[k]) begin
            @(negedge clk);
            mem_ready = rd[k];
            br_taken  = (ph[k] == P_E) ? br : 1'($urandom_range(0, 1));
            run       = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("ir=%h cyc%0d ph%0d", instr, k, ph[k]), 32'(obs),
                32'(exp_vec(ph[k], c, rd[k], br_taken, 2'd0)));
        end
        exp_ret = (exp_ret + 1) % (1 << CW);
        // Back in FETCH, idle: nothing asserted, count advanced by one
        @(negedge clk);
        run = 1'b0; mem_ready = 1'b1; #1;
        chk($sformatf("idle after %h", instr), 32'(obs), 32'd0);
        chk($sformatf("instret after %h", instr), 32'(instret), 32'(exp_ret));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", 32'(obs), 32'd0);
        chk("reset instret", 32'(instret), 32'd0);
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] instr;
        int c0;
        // Reset state with run and mem_ready high must still show all zero
        run = 1'b1; mem_ready = 1'b1;
        #3;
        chk("por outputs", 32'(obs), 32'd0);
        chk("por instret", 32'(instret), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        @(negedge clk); #1;
        chk("idle run=0", 32'(obs), 32'd0);

        // Directed test-plan instructions
        do_instr(32'h00500093, 1'b0, 0, 0);   // ADDI
        do_instr(32'h0000A103, 1'b0, 0, 3);   // LW, memory slow
        do_instr(32'h00208463, 1'b1, 0, 0);   // BEQ taken
        do_instr(32'h00208463, 1'b0, 0, 0);   // BEQ not taken
        do_instr(32'h008000EF, 1'b0, 0, 0);   // JAL
        do_instr(32'h123450B7, 1'b0, 0, 0);   // LUI
        do_instr(32'h0020A223, 1'b0, 2, 1);   // SW
        do_instr(32'h002081B3, 1'b1, 3, 0);   // ADD, fetch slow

        // Random legal instructions; count wraps past 2^CW
        for (int n = 0; n < 30; n++) begin
            c0 = int'($urandom_range(0, 6));
            instr = $urandom();
            instr[6:0] = opc_tab[c0];
            do_instr(instr, 1'($urandom_range(0, 1)), int'($urandom_range(0, TO - 1)),
                     int'($urandom_range(0, TO - 1)));
        end

        // Illegal opcode: sticky trap, no fetch, count frozen
        ir = 32'hFFFFFFFF;
        @(negedge clk); run = 1'b1; mem_ready = 1'b1; #1;
        chk("ill fetch", 32'(obs), 32'(exp_vec(P_F, C_ILL, 1'b1, 1'b0, 2'd0)));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); run = 1'b1; mem_ready = 1'($urandom_range(0, 1)); #1;
            chk($sformatf("ill trap%0d", k), 32'(obs), 32'(exp_vec(P_T, C_ILL, 1'b0, 1'b0, 2'd1)));
        end
        chk("ill instret", 32'(instret), 32'(exp_ret));
        reset_pulse();

        // Fetch timeout: TO waiting cycles with request, then trap cause 2
        ir = 32'h00500093;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk); run = 1'b1; mem_ready = 1'b0; #1;
            chk($sformatf("to wait%0d", k), 32'(obs), 32'(exp_vec(P_F, C_I, 1'b0, 1'b0, 2'd0)));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); run = 1'b1; mem_ready = 1'($urandom_range(0, 1)); #1;
            chk($sformatf("to trap%0d", k), 32'(obs), 32'(exp_vec(P_T, C_I, 1'b0, 1'b0, 2'd2)));
        end
        reset_pulse();

        // Async reset in the middle of a fetch wait
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); run = 1'b1; mem_ready = 1'b0; #1;
            chk($sformatf("rst wait%0d", k), 32'(obs), 32'(exp_vec(P_F, C_I, 1'b0, 1'b0, 2'd0)));
        end
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("rst mid-wait", 32'(obs), 32'd0);
        @(negedge clk); rst_n = 1'b1; run = 1'b0;

        // Normal operation resumes after reset
        do_instr(32'h00500093, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
